// File: rtl/b16_mem_pkg.sv
// Shared definitions for the b16 memory-bus responders: SRAM controller
// state encoding, default strobe width and byte-lane mask constants.
package b16_mem_pkg;

    // SRAM access sequencer states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ACC   = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        DONE     = 3'd5
    } mem_state_t;

    // Default strobe width in clk cycles (read access / WE pulse)
    localparam int SRAM_WAIT_DEFAULT = 2;

    // Byte-lane masks as carried on the bus w[1:0]
    localparam logic [1:0] BL_LO  = 2'b01;
    localparam logic [1:0] BL_HI  = 2'b10;
    localparam logic [1:0] BL_ALL = 2'b11;

endpackage

// File: rtl/sram_ctrl.sv
// Bus responder between the b16 memory bus and an asynchronous 16-bit SRAM.
// One read or byte-masked write per request; the initiator is held with
// ready until the access completes. Every SRAM pin comes straight from a
// register, so there is no path from bus inputs to the pads.
module sram_ctrl
    import b16_mem_pkg::*;
#(
    parameter int WAIT    = SRAM_WAIT_DEFAULT,  // strobe width, 1..15
    parameter int SRAM_AW = 18                  // SRAM word-address width
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sel,
    input  logic               r,
    input  logic [1:0]         w,
    input  logic [15:0]        addr,
    input  logic [15:0]        din,
    output logic [15:0]        dout,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [15:0]        sram_dq_i,
    output logic [15:0]        sram_dq_o,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    // Counter preload: the counted phase lasts WAIT cycles (WAIT-1 down to 0)
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT - 1);

    mem_state_t         state;
    logic [3:0]         wait_cnt;
    logic [SRAM_AW-1:0] addr_q;
    logic [15:0]        din_q;
    logic               is_wr;
    logic               req;

    // A write mask wins over r when both are present
    assign is_wr = (w != 2'b00);
    assign req   = sel & (r | is_wr);

    // Only combinational output: idle bus never stalls, a request is
    // released in the single DONE cycle
    assign ready = ~req | (state == DONE);

    // Address and write data are driven from their latches at all times
    assign sram_addr = addr_q;
    assign sram_dq_o = din_q;

    // Access sequencer with registered strobes, latches and read capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the latches and dout are part of the visible reset state,
            // so they are cleared here along with the control registers.
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            addr_q     <= '0;
            din_q      <= 16'h0000;
            dout       <= 16'h0000;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here sees the pre-edge value of every other one.
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q    <= SRAM_AW'(addr[15:1]);
                        din_q     <= din;
                        wait_cnt  <= WAIT_LOAD;
                        sram_ce_n <= 1'b0;
                        if (is_wr) begin
                            // Data drives the bus from setup; WE follows a cycle later
                            state      <= WR_SETUP;
                            sram_dq_oe <= 1'b1;
                            sram_ub_n  <= ~w[1];
                            sram_lb_n  <= ~w[0];
                        end else begin
                            // Reads always fetch both lanes
                            state     <= RD_ACC;
                            sram_oe_n <= 1'b0;
                            sram_ub_n <= ~BL_ALL[1];
                            sram_lb_n <= ~BL_ALL[0];
                        end
                    end
                end

                RD_ACC: begin
                    if (wait_cnt == 4'd0) begin
                        dout      <= sram_dq_i;
                        state     <= DONE;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                WR_SETUP: begin
                    state     <= WR_PULSE;
                    sram_we_n <= 1'b0;
                end

                WR_PULSE: begin
                    if (wait_cnt == 4'd0) begin
                        // WE rises first; CE, lanes and data hold one more cycle
                        state     <= WR_HOLD;
                        sram_we_n <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                WR_HOLD: begin
                    state      <= DONE;
                    sram_ce_n  <= 1'b1;
                    sram_ub_n  <= 1'b1;
                    sram_lb_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end

                DONE: begin
                    state <= IDLE;
                end

                // NOTE: the default arm recovers unused encodings to IDLE
                // rather than leaving them as lock-up states.
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Bus responder between the b16 CPU/debug memory bus (initiator) and the board's asynchronous 16-bit SRAM.
- Accepts one read or byte-masked write per request and holds the initiator with `ready` until the SRAM access completes.
- Sequences CE/OE/WE/UB/LB with setup, strobe and hold phases, using a programmable strobe width.
- Replaces ad-hoc SRAM strobe logic at top level; the top keeps only the DQ tri-state buffer.

Parameters:
- WAIT, 2: strobe width in clk cycles for the read access and the write WE pulse; legal range 1..15.
- SRAM_AW, 18: SRAM word-address width. CPU word address is zero-extended into it.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high reset
- sel  in  1  address decoder selects SRAM region
- r  in  1  read request
- w  in  2  byte write enables: [1] = high byte, [0] = low byte
- addr  in  16  byte address; addr[15:1] is the word address, addr[0] is ignored
- din  in  16  write data
- dout  out  16  read data, registered
- ready  out  1  high = initiator may advance (combinational)
- sram_addr  out  SRAM_AW  word address
- sram_dq_i  in  16  DQ from pad
- sram_dq_o  out  16  DQ to pad
- sram_dq_oe  out  1  pad output enable
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  active-low strobes

Behaviour:
- Request condition: `req = sel & (r | (w != 0))`. If w and r are both set, the write wins and r is ignored.
- ready:
  - ready = ~req | (state == DONE).
  - Outside a request, the initiator never stalls.
  - ready is the only combinational output.
  - All SRAM pins are decoded from registered state and registered latches only; no input-to-pin paths.
- States: IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- Transitions out of IDLE:
  - On req, latch addr[15:1], din and w (the latches hold w=2'b11 for reads).
  - Go to WR_SETUP if w != 0, else RD_ACC.
  - Load the 4-bit wait counter with WAIT-1.
- RD_ACC:
  - ce_n=0, oe_n=0, ub_n=lb_n=0, dq_oe=0.
  - Counter decrements each cycle. When counter == 0, capture sram_dq_i into dout and go to DONE.
- WR_SETUP (1 cycle):
  - ce_n=0, dq_oe=1, we_n=1, ub_n/lb_n = ~latched w.
  - Go to WR_PULSE.
- WR_PULSE:
  - As WR_SETUP but we_n=0, for WAIT cycles via the counter.
  - Go to WR_HOLD.
- WR_HOLD (1 cycle):
  - we_n=1, ce_n=0, dq_oe=1; data and address stay stable.
  - Go to DONE.
- DONE (1 cycle):
  - All strobes deasserted (high), dq_oe=0.
  - Go to IDLE unconditionally. A back-to-back request is accepted the following cycle.
- Latency, with cycle 0 = request seen in IDLE:
  - Read: ready is low for cycles 0..WAIT and high in cycle WAIT+1. dout is valid from cycle WAIT+1 and held until the next read capture.
  - Write: ready is low for cycles 0..WAIT+2 and high in cycle WAIT+3.
- sram_addr = {zeros, latched addr[15:1]}. It is held from the cycle after acceptance through DONE and is don't-care otherwise (the implementation keeps the last value).
- sram_dq_o = latched din at all times. It is only meaningful while dq_oe=1.
- sel or r/w changing mid-access has no effect: the operation completes with the latched values.
- Reset, at any time including mid-write:
  - state=IDLE.
  - ce_n=oe_n=we_n=ub_n=lb_n=1, dq_oe=0.
  - dout=0, sram_addr=0, latches=0.
- Bus turnaround: dq_oe is never 1 in a cycle where oe_n=0.

Decomposition:
- Package b16_mem_pkg holds:
  - the state enum (3-bit encoding);
  - SRAM_WAIT_DEFAULT = 2;
  - the byte-lane mask constants BL_LO = 2'b01, BL_HI = 2'b10, BL_ALL = 2'b11.
- A single module is sufficient. The wait counter is inline; no sub-module.

Test Plan:
- Reset asserted mid-WR_PULSE:
  - we_n goes to 1 and dq_oe to 0 immediately (asynchronous).
  - After release, state is IDLE and ready=1 with sel=0.
  - The SRAM model shows no partial-write corruption beyond the addressed word.
- Write then read, WAIT=2:
  - Write addr=0x4A2C, din=0xBEEF, w=2'b11.
  - Checks: sram_addr=0x02516; WE low exactly 2 cycles; ready high in cycle 5.
  - Read back the same address: dout=0xBEEF with ready high in cycle 3.
- Byte lanes:
  - Write 0x1234 to word 0x0100, then w=2'b10 with din=0xAB00, then w=2'b01 with din=0x00CD.
  - Checks: ub_n/lb_n follow the mask during WR_SETUP..WR_HOLD; a subsequent read returns 0xABCD.
- Read/write conflict and stability:
  - Assert r=1 and w=2'b01 together: the controller performs a write.
  - Change addr and din during WR_PULSE: sram_addr and sram_dq_o stay at the latched values.
- Back-to-back and idle:
  - Three consecutive reads: each is accepted the cycle after DONE, and ready=1 for exactly one cycle between them.
  - With sel=0 and r=1: ready stays 1 and all strobes stay high.
- Turnaround check over 1000 random accesses (WAIT random 1..15):
  - Assert that dq_oe & ~oe_n never occurs.
  - Assert that the ready-low duration equals WAIT+1 for reads and WAIT+3 for writes.
